// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared definitions for the multi-channel symmetrical PWM generator:
//   default widths, the shadow-update mode constants and the per-channel
//   dead-time state encoding.
package pwm_pkg;

  localparam int N_CH_DEF  = 3;
  localparam int CNT_W_DEF = 16;
  localparam int DT_W_DEF  = 8;

  // Shadow register update point
  localparam int UPD_HALF = 0;  // load on every sync_phase toggle
  localparam int UPD_FULL = 1;  // load only on sync_phase 1->0

  // Stage-2 dead-time FSM states. *_ARM = that side is pending while the
  // dead-time counter runs, both gates are off.
  typedef enum logic [2:0] {
    OFF      = 3'd0,
    HIGH_ARM = 3'd1,
    HIGH_ON  = 3'd2,
    LOW_ARM  = 3'd3,
    LOW_ON   = 3'd4
  } dt_state_e;

endpackage

// File: rtl/pwm_deadtime_channel.sv
// pwm_deadtime_channel
//   Stage 2 of one PWM channel: turns the registered raw compare into a
//   complementary high/low gate pair with a dead time inserted before either
//   side turns on.
// Ports:
//   clk_i, rst_n_i  clock, async active-low reset
//   raw_i           stage-1 compare result (already gated by enable)
//   force_off_i     trip / disabled: both gates off, counter cleared
//   deadtime_i      dead time in clk_i cycles, sampled when an edge arms a side
//   pwm_h_o/pwm_l_o high-side / low-side gate
module pwm_deadtime_channel
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            raw_i,
  input  logic            force_off_i,
  input  logic [DT_W-1:0] deadtime_i,
  output logic            pwm_h_o,
  output logic            pwm_l_o
);

  dt_state_e       state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            side_high;  // side the current state belongs to
  logic            need_arm;   // raw disagrees with the current side, or OFF

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    side_high = (state_q == HIGH_ARM) || (state_q == HIGH_ON);
    need_arm  = (state_q == OFF) || (raw_i != side_high);
    if (force_off_i) begin
      state_d = OFF;
      cnt_d   = '0;
    end else if (need_arm) begin
      // A new edge always restarts the dead time for the side raw now
      // selects; a side still pending in *_ARM is abandoned.
      if (deadtime_i == '0) begin
        state_d = raw_i ? HIGH_ON : LOW_ON;
        cnt_d   = '0;
      end else begin
        state_d = raw_i ? HIGH_ARM : LOW_ARM;
        cnt_d   = deadtime_i;
      end
    end else begin
      case (state_q)
        HIGH_ARM, LOW_ARM: begin
          // The ARM state itself is the first dead cycle, so the side turns
          // on after exactly deadtime_i cycles with both gates low.
          if (cnt_q <= DT_W'(1)) begin
            state_d = (state_q == HIGH_ARM) ? HIGH_ON : LOW_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        default: begin
          state_d = state_q;
          cnt_d   = cnt_q;
        end
      endcase
    end
  end

  // outputs: decoded from the state register, never both high
  always_comb begin
    pwm_h_o = (state_q == HIGH_ON);
    pwm_l_o = (state_q == LOW_ON);
  end

endmodule

// File: rtl/multi_channel_sym_pwm.sv
// multi_channel_sym_pwm
//   N-channel symmetrical (centre-aligned) PWM with complementary gates,
//   dead time, shadowed duty/enable and a sticky trip zone. Runs from the
//   shared Local_clock timebase.
// Ports:
//   clk_i, rst_n_i    timebase clock, async active-low reset
//   current_period_i  period running in Local_clock
//   local_counter_i   Local_clock counter, 0..current_period_i per half-period
//   sync_phase_i      0 = rising half of the carrier, 1 = falling half
//   duty_i            compare value per channel, channel k at [k*CNT_W +: CNT_W]
//   enable_i          output enable per channel
//   deadtime_i        dead time in clk_i cycles, common to all channels
//   tz_i              trip zone, active high
//   pwm_h_o/pwm_l_o   high/low-side gates per channel
//   tripped_o         sticky trip flag
//   load_o            one-cycle pulse while freshly loaded shadows take effect
module multi_channel_sym_pwm
  import pwm_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DT_W        = DT_W_DEF,
  parameter int UPDATE_MODE = UPD_HALF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [CNT_W-1:0]      current_period_i,
  input  logic [CNT_W-1:0]      local_counter_i,
  input  logic                  sync_phase_i,
  input  logic [N_CH*CNT_W-1:0] duty_i,
  input  logic [N_CH-1:0]       enable_i,
  input  logic [DT_W-1:0]       deadtime_i,
  input  logic                  tz_i,
  output logic [N_CH-1:0]       pwm_h_o,
  output logic [N_CH-1:0]       pwm_l_o,
  output logic                  tripped_o,
  output logic                  load_o
);

  logic                        phase_q, phase_d;
  logic                        load_q, load_d;
  logic                        tripped_q, tripped_d;
  logic [N_CH-1:0][CNT_W-1:0]  duty_sh_q, duty_sh_d;
  logic [N_CH-1:0]             en_sh_q, en_sh_d;
  logic [N_CH-1:0]             raw_q, raw_d;
  logic [N_CH-1:0]             en_p_q, en_p_d;   // enable aligned with raw_q
  logic [N_CH-1:0][CNT_W-1:0]  duty_in;
  logic [N_CH-1:0]             force_off;
  logic                        toggle;
  logic [CNT_W-1:0]            carrier;

  assign duty_in = duty_i;

  // Shadow update point
  always_comb begin
    phase_d = sync_phase_i;
    toggle  = phase_q ^ sync_phase_i;
    if (UPDATE_MODE == UPD_FULL) load_d = toggle & phase_q;  // 1->0 only
    else                         load_d = toggle;
  end

  // Shadow registers and trip flag. A trip in the same cycle as a load wins:
  // the duty is still taken but the enables stay cleared.
  always_comb begin
    duty_sh_d = load_d ? duty_in : duty_sh_q;
    en_sh_d   = en_sh_q;
    tripped_d = tripped_q;
    if (tz_i) begin
      en_sh_d   = '0;
      tripped_d = 1'b1;
    end else if (load_d) begin
      en_sh_d   = enable_i;
      tripped_d = 1'b0;
    end
  end

  // Triangle carrier. local_counter_i <= current_period_i is guaranteed by
  // the timebase, so the subtraction cannot wrap.
  always_comb begin
    carrier = sync_phase_i ? (current_period_i - local_counter_i) : local_counter_i;
  end

  // Stage 1: raw compare gated by the shadow enable
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      raw_d[k] = en_sh_q[k] & (carrier < duty_sh_q[k]);
    end
    en_p_d = en_sh_q;
  end

  // tz_i acts directly on stage 2 so the gates drop the cycle after the trip;
  // tripped_q and the delayed enable keep them down until a clean reload.
  always_comb begin
    force_off = {N_CH{tz_i | tripped_q}} | ~en_p_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase_q   <= 1'b0;
      load_q    <= 1'b0;
      tripped_q <= 1'b0;
      duty_sh_q <= '0;
      en_sh_q   <= '0;
      raw_q     <= '0;
      en_p_q    <= '0;
    end else begin
      phase_q   <= phase_d;
      load_q    <= load_d;
      tripped_q <= tripped_d;
      duty_sh_q <= duty_sh_d;
      en_sh_q   <= en_sh_d;
      raw_q     <= raw_d;
      en_p_q    <= en_p_d;
    end
  end

  // Stage 2: dead-time FSM per channel
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pwm_deadtime_channel #(
      .DT_W (DT_W)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .raw_i       (raw_q[k]),
      .force_off_i (force_off[k]),
      .deadtime_i  (deadtime_i),
      .pwm_h_o     (pwm_h_o[k]),
      .pwm_l_o     (pwm_l_o[k])
    );
  end

  assign tripped_o = tripped_q;
  assign load_o    = load_q;

endmodule

// File: tb/tb_multi_channel_sym_pwm.sv
// Bench for multi_channel_sym_pwm: one DUT per update mode fed from a common
// timebase; a behavioural model pushes expected outputs into a scoreboard
// queue each cycle, popped and compared after the clock edge.
module tb_multi_channel_sym_pwm;

  localparam int N  = 3;
  localparam int CW = 16;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CW-1:0]   period = 16'd99;
  logic [CW-1:0]   lcnt = '0;
  logic            sph = 1'b0;
  logic [N*CW-1:0] duty = '0;
  logic [N-1:0]    en = '0;
  logic [DW-1:0]   dt = '0;
  logic            tz = 1'b0;
  logic [N-1:0]    h0, l0, h1, l1;
  logic            trip0, trip1, ld0, ld1;

  always #5 clk = ~clk;

  multi_channel_sym_pwm #(.N_CH(N), .CNT_W(CW), .DT_W(DW), .UPDATE_MODE(0)) u_dut_half (
    .clk_i(clk), .rst_n_i(rst_n), .current_period_i(period), .local_counter_i(lcnt),
    .sync_phase_i(sph), .duty_i(duty), .enable_i(en), .deadtime_i(dt), .tz_i(tz),
    .pwm_h_o(h0), .pwm_l_o(l0), .tripped_o(trip0), .load_o(ld0));

  multi_channel_sym_pwm #(.N_CH(N), .CNT_W(CW), .DT_W(DW), .UPDATE_MODE(1)) u_dut_full (
    .clk_i(clk), .rst_n_i(rst_n), .current_period_i(period), .local_counter_i(lcnt),
    .sync_phase_i(sph), .duty_i(duty), .enable_i(en), .deadtime_i(dt), .tz_i(tz),
    .pwm_h_o(h1), .pwm_l_o(l1), .tripped_o(trip1), .load_o(ld1));

  typedef struct packed {
    logic [N-1:0] h;
    logic [N-1:0] l;
    logic         trip;
    logic         load;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // stimulus-side variables
  int tb_cnt = 0;
  bit tb_ph  = 0;
  int tb_duty[N];

  // model state, index 0 = half-period update, 1 = full-period update
  bit m_ph[2];
  int m_duty[2][N];
  bit m_en[2][N];
  bit m_trip[2];
  bit m_load[2];
  bit m_raw1[2][N];
  bit m_en1[2][N];
  bit m_act[2][N];
  bit m_tgt[2][N];
  int m_age[2][N];
  int m_dtl[2][N];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ph[m] = 0; m_trip[m] = 0; m_load[m] = 0;
      for (int k = 0; k < N; k++) begin
        m_duty[m][k] = 0; m_en[m][k] = 0; m_raw1[m][k] = 0; m_en1[m][k] = 0;
        m_act[m][k] = 0; m_tgt[m][k] = 0; m_age[m][k] = 0; m_dtl[m][k] = 0;
      end
    end
    sb_q.delete();
  endtask

  // Predict the outputs visible after the next clock edge from the inputs
  // currently driven.
  task automatic model_step();
    exp_t e;
    bit   tog, ld, frc;
    bit   nraw[N];
    int   car;
    car = tb_ph ? (int'(period) - tb_cnt) : tb_cnt;
    for (int m = 0; m < 2; m++) begin
      tog = (tb_ph != m_ph[m]);
      ld  = (m == 1) ? (m_ph[m] && !tb_ph) : tog;
      for (int k = 0; k < N; k++) begin
        frc = tz || m_trip[m] || !m_en1[m][k];
        if (frc) begin
          m_act[m][k] = 0;
        end else if (!m_act[m][k] || (m_raw1[m][k] != m_tgt[m][k])) begin
          m_act[m][k] = 1; m_tgt[m][k] = m_raw1[m][k];
          m_age[m][k] = 0; m_dtl[m][k] = int'(dt);
        end else if (m_age[m][k] < 1000) begin
          m_age[m][k]++;
        end
        nraw[k] = m_en[m][k] && (car < m_duty[m][k]);
      end
      for (int k = 0; k < N; k++) begin
        m_raw1[m][k] = nraw[k];
        m_en1[m][k]  = m_en[m][k];
        if (ld) m_duty[m][k] = tb_duty[k];
      end
      if (tz) begin
        m_trip[m] = 1;
        for (int k = 0; k < N; k++) m_en[m][k] = 0;
      end else if (ld) begin
        m_trip[m] = 0;
        for (int k = 0; k < N; k++) m_en[m][k] = en[k];
      end
      m_load[m] = ld;
      m_ph[m]   = tb_ph;
      for (int k = 0; k < N; k++) begin
        e.h[k] = m_act[m][k] && m_tgt[m][k] && (m_age[m][k] >= m_dtl[m][k]);
        e.l[k] = m_act[m][k] && !m_tgt[m][k] && (m_age[m][k] >= m_dtl[m][k]);
      end
      e.trip = m_trip[m];
      e.load = m_load[m];
      sb_q.push_back(e);
    end
  endtask

  // One timebase cycle: drive, predict, clock, compare, advance the counter.
  task automatic tick();
    exp_t e;
    lcnt = CW'(tb_cnt);
    sph  = tb_ph;
    for (int k = 0; k < N; k++) duty[k*CW +: CW] = CW'(tb_duty[k]);
    model_step();
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("m%0d_pwm_h", m), int'(m ? h1 : h0), int'(e.h));
        chk($sformatf("m%0d_pwm_l", m), int'(m ? l1 : l0), int'(e.l));
        chk($sformatf("m%0d_tripped", m), int'(m ? trip1 : trip0), int'(e.trip));
        chk($sformatf("m%0d_load", m), int'(m ? ld1 : ld0), int'(e.load));
        chk($sformatf("m%0d_overlap", m), int'(m ? (h1 & l1) : (h0 & l0)), 0);
      end
    end
    if (tb_cnt >= int'(period)) begin
      tb_cnt = 0;
      tb_ph  = !tb_ph;
    end else begin
      tb_cnt++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the timebase reaches a given point (bounded).
  task automatic run_until(input bit ph, input int c);
    int guard = 0;
    while (!(tb_ph == ph && tb_cnt == c) && guard < 1000) begin
      tick();
      guard++;
    end
    chk("run_until_bound", int'(guard >= 1000), 0);
  endtask

  // Observe channel ch on the half-mode DUT over n cycles.
  task automatic measure(input int n, input int ch, output int hc, output int zc,
                         output int lc0, output int lc1);
    hc = 0; zc = 0; lc0 = 0; lc1 = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (h0[ch]) hc++;
      if (!h0[ch] && !l0[ch]) zc++;
      if (ld0) lc0++;
      if (ld1) lc1++;
    end
  endtask

  initial begin
    int hc, zc, lc0, lc1;
    for (int k = 0; k < N; k++) tb_duty[k] = 0;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_h", int'({h1, h0}), 0);
    chk("rst_l", int'({l1, l0}), 0);
    chk("rst_trip", int'({trip1, trip0}), 0);
    chk("rst_load", int'({ld1, ld0}), 0);
    rst_n = 1'b1;

    // dt 0, ch0 duty 50, ch1 duty 0, ch2 duty above period
    tb_duty[0] = 50; tb_duty[1] = 0; tb_duty[2] = 200;
    en = 3'b111; dt = 8'd0;
    run(450);
    measure(200, 0, hc, zc, lc0, lc1);
    chk("d50_high_cycles", hc, 100);
    chk("d50_dead_cycles", zc, 0);
    chk("loads_half_mode", lc0, 2);
    chk("loads_full_mode", lc1, 1);
    chk("duty0_h", int'({h1[1], h0[1]}), 0);
    chk("duty0_l", int'({l1[1], l0[1]}), 3);
    chk("dutymax_h", int'({h1[2], h0[2]}), 3);
    chk("dutymax_l", int'({l1[2], l0[2]}), 0);

    // dead time 5
    dt = 8'd5;
    run(300);
    measure(200, 0, hc, zc, lc0, lc1);
    chk("dt5_dead_cycles", zc, 10);
    chk("dt5_high_cycles", hc, 95);

    // duty change in the middle of the rising half
    run_until(1'b0, 30);
    tb_duty[0] = 20;
    run(500);
    measure(200, 0, hc, zc, lc0, lc1);
    chk("d20_high_cycles", hc, 35);

    // one-cycle trip during the ch0 pulse
    run_until(1'b1, 90);
    tz = 1'b1;
    tick();
    tz = 1'b0;
    chk("trip_flag", int'({trip1, trip0}), 3);
    chk("trip_h_off", int'({h1, h0}), 0);
    chk("trip_l_off", int'({l1, l0}), 0);
    run(500);
    chk("trip_cleared", int'({trip1, trip0}), 0);

    // short raw pulse swallowed by a longer dead time
    dt = 8'd10; tb_duty[0] = 2;
    run(500);
    measure(200, 0, hc, zc, lc0, lc1);
    chk("short_high_cycles", hc, 0);
    chk("short_dead_cycles", zc, 14);

    // async reset while ch2 high side is on
    chk("pre_rst_ch2_h", int'(h0[2]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_h", int'({h1, h0}), 0);
    chk("async_rst_l", int'({l1, l0}), 0);
    chk("async_rst_trip", int'({trip1, trip0}), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    en = 3'b000;
    measure(300, 2, hc, zc, lc0, lc1);
    chk("post_rst_dis_dead", zc, 300);
    en = 3'b111;
    run(400);
    chk("reenable_ch2_h", int'({h1[2], h0[2]}), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
